eth_tx_framer: RTL and testbench

- Transmit-side counterpart of the receive dispatcher in the UDP/ARP stack.
- Arbitrates between the ARP-reply and IP payload byte streams (8-bit AXI-Stream).
- Prepends the 14-byte Ethernet header (destination MAC, source MAC, EtherType) and pads runt frames to 60 bytes.
- Emits one byte stream towards the MAC TX FIFO; the MAC appends the FCS.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Ethernet framing constants and types shared by the TX framer and the RX dispatcher.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam int          ETH_HDR_LEN  = 14;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PAD,
        DROP,
        GAP
    } frame_state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_hdr_t;

endpackage

// File: rtl/eth_tx_framer.sv
// Arbitrates ARP/IP payload streams, prepends the Ethernet header, pads runts,
// truncates oversize frames and enforces the inter-frame gap.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME  = 60,
    parameter int MAX_FRAME  = 1514,
    parameter int IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] local_mac_addr_in,
    input  logic [47:0] arp_dst_mac_in,
    input  logic [47:0] ip_dst_mac_in,
    input  logic [7:0]  arp_axis_tdata_in,
    input  logic        arp_axis_tvalid_in,
    input  logic        arp_axis_tlast_in,
    output logic        arp_axis_tready_o,
    input  logic [7:0]  ip_axis_tdata_in,
    input  logic        ip_axis_tvalid_in,
    input  logic        ip_axis_tlast_in,
    output logic        ip_axis_tready_o,
    output logic [7:0]  axis_tdata_out,
    output logic        axis_tvalid_out,
    output logic        axis_tlast_out,
    input  logic        axis_tready_in,
    output logic        frame_trunc_o
);

    localparam logic [10:0] HDR_LAST = 11'(ETH_HDR_LEN - 1);
    localparam logic [10:0] MIN_LAST = 11'(MIN_FRAME - 1);
    localparam logic [10:0] MAX_LAST = 11'(MAX_FRAME - 1);
    localparam int          GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);

    frame_state_t  state;
    eth_hdr_t      hdr;
    logic          sel;       // 0 = ARP, 1 = IP
    logic [10:0]   byte_cnt;
    logic [GW-1:0] gap_cnt;

    logic [7:0] src_data;
    logic [7:0] hdr_byte;
    logic       src_valid;
    logic       src_last;
    logic       src_ready;

    assign src_data  = sel ? ip_axis_tdata_in  : arp_axis_tdata_in;
    assign src_valid = sel ? ip_axis_tvalid_in : arp_axis_tvalid_in;
    assign src_last  = sel ? ip_axis_tlast_in  : arp_axis_tlast_in;

    assign arp_axis_tready_o = src_ready & ~sel;
    assign ip_axis_tready_o  = src_ready & sel;

    always_comb begin
        hdr_byte = 8'h00;
        case (byte_cnt[3:0])
            4'd0:    hdr_byte = hdr.dst_mac[47:40];
            4'd1:    hdr_byte = hdr.dst_mac[39:32];
            4'd2:    hdr_byte = hdr.dst_mac[31:24];
            4'd3:    hdr_byte = hdr.dst_mac[23:16];
            4'd4:    hdr_byte = hdr.dst_mac[15:8];
            4'd5:    hdr_byte = hdr.dst_mac[7:0];
            4'd6:    hdr_byte = hdr.src_mac[47:40];
            4'd7:    hdr_byte = hdr.src_mac[39:32];
            4'd8:    hdr_byte = hdr.src_mac[31:24];
            4'd9:    hdr_byte = hdr.src_mac[23:16];
            4'd10:   hdr_byte = hdr.src_mac[15:8];
            4'd11:   hdr_byte = hdr.src_mac[7:0];
            4'd12:   hdr_byte = hdr.eth_type[15:8];
            4'd13:   hdr_byte = hdr.eth_type[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Payload is a zero-latency pass-through, so outputs decode from state.
    always_comb begin
        axis_tvalid_out = 1'b0;
        axis_tdata_out  = 8'h00;
        axis_tlast_out  = 1'b0;
        frame_trunc_o   = 1'b0;
        src_ready       = 1'b0;
        case (state)
            HEADER: begin
                axis_tvalid_out = 1'b1;
                axis_tdata_out  = hdr_byte;
            end
            PAYLOAD: begin
                axis_tvalid_out = src_valid;
                axis_tdata_out  = src_data;
                src_ready       = axis_tready_in;
                if (src_valid && src_last && byte_cnt >= MIN_LAST)
                    axis_tlast_out = 1'b1;
                if (src_valid && !src_last && byte_cnt == MAX_LAST) begin
                    axis_tlast_out = 1'b1;
                    frame_trunc_o  = axis_tready_in;
                end
            end
            PAD: begin
                axis_tvalid_out = 1'b1;
                axis_tlast_out  = (byte_cnt == MIN_LAST);
            end
            DROP:    src_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hdr      <= '0;
            sel      <= 1'b0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arp_axis_tvalid_in) begin
                        sel   <= 1'b0;
                        hdr   <= '{dst_mac: arp_dst_mac_in, src_mac: local_mac_addr_in,
                                   eth_type: ETH_TYPE_ARP};
                        state <= HEADER;
                    end else if (ip_axis_tvalid_in) begin
                        sel   <= 1'b1;
                        hdr   <= '{dst_mac: ip_dst_mac_in, src_mac: local_mac_addr_in,
                                   eth_type: ETH_TYPE_IP};
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (axis_tready_in) begin
                        byte_cnt <= byte_cnt + 11'd1;
                        if (byte_cnt == HDR_LAST) state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (src_valid && axis_tready_in) begin
                        if (src_last) begin
                            if (byte_cnt < MIN_LAST) begin
                                byte_cnt <= byte_cnt + 11'd1;
                                state    <= PAD;
                            end else begin
                                byte_cnt <= '0;
                                state    <= GAP;
                            end
                        end else if (byte_cnt == MAX_LAST) begin
                            state <= DROP;
                        end else begin
                            byte_cnt <= byte_cnt + 11'd1;
                        end
                    end
                end
                PAD: begin
                    if (axis_tready_in) begin
                        if (byte_cnt == MIN_LAST) begin
                            byte_cnt <= '0;
                            state    <= GAP;
                        end else begin
                            byte_cnt <= byte_cnt + 11'd1;
                        end
                    end
                end
                DROP: begin
                    if (src_valid && src_last) begin
                        byte_cnt <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: sources and sink are driven independently,
// expected frames are built from the header/pad/truncate rules and checked per beat.
module tb_eth_tx_framer;

    localparam int MIN_FRAME  = 60;
    localparam int MAX_FRAME  = 1514;
    localparam int IFG_CYCLES = 12;

    logic        clk, reset;
    logic [47:0] local_mac, arp_dst, ip_dst;
    logic [7:0]  arp_tdata, ip_tdata, axis_tdata_out;
    logic        arp_tvalid, arp_tlast, arp_axis_tready_o;
    logic        ip_tvalid, ip_tlast, ip_axis_tready_o;
    logic        axis_tvalid_out, axis_tlast_out, axis_tready_in, frame_trunc_o;

    eth_tx_framer #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .IFG_CYCLES(IFG_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .local_mac_addr_in(local_mac), .arp_dst_mac_in(arp_dst), .ip_dst_mac_in(ip_dst),
        .arp_axis_tdata_in(arp_tdata), .arp_axis_tvalid_in(arp_tvalid),
        .arp_axis_tlast_in(arp_tlast), .arp_axis_tready_o(arp_axis_tready_o),
        .ip_axis_tdata_in(ip_tdata), .ip_axis_tvalid_in(ip_tvalid),
        .ip_axis_tlast_in(ip_tlast), .ip_axis_tready_o(ip_axis_tready_o),
        .axis_tdata_out(axis_tdata_out), .axis_tvalid_out(axis_tvalid_out),
        .axis_tlast_out(axis_tlast_out), .axis_tready_in(axis_tready_in),
        .frame_trunc_o(frame_trunc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int beats = 0;
    int trunc_seen = 0;
    int rdy_mode = 0;
    bit gap_en = 1'b0;
    bit abort = 1'b0;

    logic [8:0] exp_q[$];
    logic [8:0] arp_q[$];
    logic [8:0] ip_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected frame: header, payload, zero pad up to MIN_FRAME, cut at MAX_FRAME.
    function automatic void send(input bit is_arp, input logic [47:0] dst,
                                 input logic [47:0] src, input int len, input bit ramp);
        logic [111:0] h;
        logic [7:0]   pl[$];
        logic [7:0]   b;
        int           n;
        h = {dst, src, is_arp ? 16'h0806 : 16'h0800};
        local_mac = src;
        if (is_arp) arp_dst = dst; else ip_dst = dst;
        for (int i = 0; i < len; i++) begin
            b = ramp ? 8'(i + 1) : 8'($urandom);
            pl.push_back(b);
            if (is_arp) arp_q.push_back({i == len - 1, b});
            else        ip_q.push_back({i == len - 1, b});
        end
        n = 14 + len;
        if (n > MAX_FRAME) n = MAX_FRAME;
        if (n < MIN_FRAME) n = MIN_FRAME;
        for (int k = 0; k < n; k++) begin
            if (k < 14)            b = h[111 - 8*k -: 8];
            else if (k - 14 < len) b = pl[k - 14];
            else                   b = 8'h00;
            exp_q.push_back({k == n - 1, b});
        end
    endfunction

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || arp_q.size() != 0 || ip_q.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done"}, 32'(exp_q.size() + arp_q.size() + ip_q.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_tvalid"}, 32'(axis_tvalid_out), 32'd0);
        check({name, "_tlast"},  32'(axis_tlast_out),  32'd0);
        check({name, "_tdata"},  32'(axis_tdata_out),  32'd0);
        check({name, "_arprdy"}, 32'(arp_axis_tready_o), 32'd0);
        check({name, "_iprdy"},  32'(ip_axis_tready_o),  32'd0);
        check({name, "_trunc"},  32'(frame_trunc_o),   32'd0);
    endtask

    // ARP source driver; holds a presented beat until it is accepted.
    initial begin
        bit xfer;
        arp_tvalid = 1'b0; arp_tdata = 8'h00; arp_tlast = 1'b0;
        forever begin
            @(negedge clk);
            if (abort) begin arp_q.delete(); xfer = 1'b0; end
            else xfer = arp_tvalid && arp_axis_tready_o;
            @(posedge clk); #1;
            if (xfer && arp_q.size() != 0) void'(arp_q.pop_front());
            if (!abort && arp_q.size() != 0 &&
                ((arp_tvalid && !xfer) || !gap_en || $urandom_range(3) != 0)) begin
                arp_tvalid = 1'b1; {arp_tlast, arp_tdata} = arp_q[0];
            end else arp_tvalid = 1'b0;
        end
    end

    initial begin
        bit xfer;
        ip_tvalid = 1'b0; ip_tdata = 8'h00; ip_tlast = 1'b0;
        forever begin
            @(negedge clk);
            if (abort) begin ip_q.delete(); xfer = 1'b0; end
            else xfer = ip_tvalid && ip_axis_tready_o;
            @(posedge clk); #1;
            if (xfer && ip_q.size() != 0) void'(ip_q.pop_front());
            if (!abort && ip_q.size() != 0 &&
                ((ip_tvalid && !xfer) || !gap_en || $urandom_range(3) != 0)) begin
                ip_tvalid = 1'b1; {ip_tlast, ip_tdata} = ip_q[0];
            end else ip_tvalid = 1'b0;
        end
    end

    // Sink ready: 0 always on, 1 the 1,0,0,1 pattern, 2 random.
    initial begin
        int ph = 0;
        axis_tready_in = 1'b0;
        forever begin
            @(posedge clk); #1;
            ph++;
            if (abort)              axis_tready_in = 1'b0;
            else if (rdy_mode == 1) axis_tready_in = (ph % 4 == 0) || (ph % 4 == 3);
            else if (rdy_mode == 2) axis_tready_in = 1'($urandom_range(1));
            else                    axis_tready_in = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output beat.
    initial begin
        bit prev_stall = 1'b0, in_frame = 1'b0, have_prev = 1'b0;
        int idle = 0;
        logic [8:0] prev = '0, e;
        forever begin
            @(negedge clk);
            if (abort || reset) begin
                prev_stall = 1'b0; in_frame = 1'b0; have_prev = 1'b0; idle = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", 32'({axis_tvalid_out, axis_tlast_out, axis_tdata_out}),
                          32'({1'b1, prev}));
                prev_stall = axis_tvalid_out && !axis_tready_in;
                prev = {axis_tlast_out, axis_tdata_out};
                if (frame_trunc_o) begin
                    trunc_seen++;
                    check("trunc_on_last_beat",
                          32'(axis_tvalid_out && axis_tready_in && axis_tlast_out), 32'd1);
                end
                if (axis_tvalid_out && !in_frame) begin
                    if (have_prev) check("ifg_len", 32'(idle >= IFG_CYCLES), 32'd1);
                    in_frame = 1'b1;
                end else if (!axis_tvalid_out && !in_frame) idle++;
                if (axis_tvalid_out && axis_tready_in) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 {axis_tlast_out, axis_tdata_out});
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("beat%0d", beats),
                              32'({axis_tlast_out, axis_tdata_out}), 32'(e));
                    end
                    if (axis_tlast_out) begin
                        in_frame = 1'b0; have_prev = 1'b1; idle = 0;
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n, viol, t0, len;
        int lens[4] = '{1, 45, 47, 1500};
        reset = 1'b1;
        local_mac = '0; arp_dst = '0; ip_dst = '0;
        repeat (3) @(posedge clk); #1;
        check_quiet("reset");
        @(negedge clk); reset = 1'b0;

        rdy_mode = 0; gap_en = 1'b0;
        send(1'b1, 48'hFFFF_FFFF_FFFF, 48'h000A_3500_0102, 28, 1'b1);
        wait_done("arp_only", 500);

        @(negedge clk);
        send(1'b0, 48'h1122_3344_5566, 48'h000A_3500_0102, 46, 1'b0);
        wait_done("ip_min", 500);

        @(negedge clk);
        send(1'b1, {$urandom, 16'h0001}, 48'h000A_3500_0102, 28, 1'b0);
        send(1'b0, {$urandom, 16'h0002}, 48'h000A_3500_0102, 50, 1'b0);
        start = beats; n = 0; viol = 0;
        while (beats - start < 60 && n < 1000) begin
            @(negedge clk);
            if (ip_axis_tready_o) viol++;
            n++;
        end
        check("ip_blocked_during_arp", 32'(viol), 32'd0);
        wait_done("simultaneous", 1000);

        rdy_mode = 1;
        @(negedge clk);
        send(1'b1, 48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 10, 1'b0);
        wait_done("bp_pad", 1000);
        @(negedge clk);
        send(1'b0, 48'h6655_4433_2211, 48'h0A0B_0C0D_0E0F, 100, 1'b0);
        wait_done("bp_long", 1000);

        rdy_mode = 0;
        t0 = trunc_seen;
        @(negedge clk);
        send(1'b0, 48'hA1A2_A3A4_A5A6, 48'h0A0B_0C0D_0E0F, 1600, 1'b0);
        wait_done("trunc", 4000);
        check("trunc_pulses", 32'(trunc_seen - t0), 32'd1);

        @(negedge clk);
        send(1'b0, 48'hB1B2_B3B4_B5B6, 48'h0A0B_0C0D_0E0F, 40, 1'b0);
        start = beats; n = 0;
        while (beats - start < 24 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("reach_payload10", 32'(beats - start), 32'd24);
        #1;
        abort = 1'b1; axis_tready_in = 1'b0; reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_quiet("midreset");
        @(negedge clk);
        reset = 1'b0; abort = 1'b0;
        @(negedge clk);
        send(1'b1, 48'hC1C2_C3C4_C5C6, 48'h0A0B_0C0D_0E0F, 20, 1'b0);
        wait_done("after_reset", 500);

        rdy_mode = 2; gap_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            len = (i < 4) ? lens[i] : int'($urandom_range(1, 120));
            @(negedge clk);
            send(1'($urandom_range(1)), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)},
                 len, 1'b0);
            wait_done($sformatf("rand%0d", i), 8000);
        end
        check("trunc_total", 32'(trunc_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
